// File: rtl/multicycle_processor_pkg.sv
// Shared definitions for the multicycle processor: opcodes, FSM state type
// and the instruction-width derivation used by the top, the ALU and the
// bus interface.
package multicycle_processor_pkg;

    // Opcode field values (top three bits of every instruction)
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MOV = 3'b100;
    localparam logic [2:0] OP_BRZ = 3'b100;  // same encoding, selected at build time
    localparam logic [2:0] OP_HLT = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    // Instruction is op | rd | rs
    function automatic int instr_width(input int reg_addr_w);
        return 3 + 2 * reg_addr_w;
    endfunction

    // Only true ALU operations refresh the zero flag
    function automatic logic updates_zflag(input logic [2:0] op);
        return (op != OP_MOV) && (op != OP_HLT);
    endfunction

endpackage

// File: rtl/multicycle_processor_if.sv
// Host-side bus of the multicycle processor: start pulse, instruction-memory
// and register preload write ports, register readback and status outputs.
interface multicycle_processor_if
    import multicycle_processor_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int IMEM_AW    = 6
) ();

    localparam int INSTR_W = instr_width(REG_ADDR_W);

    logic                  start;
    logic                  imem_we;
    logic [IMEM_AW-1:0]    imem_addr;
    logic [INSTR_W-1:0]    imem_wdata;
    logic                  reg_we;
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0]     reg_wdata;
    logic [REG_ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0]     dbg_data;
    logic                  busy;
    logic                  halted;
    logic [IMEM_AW-1:0]    pc;
    logic                  zflag;

    modport master (
        output start, imem_we, imem_addr, imem_wdata,
        output reg_we, reg_addr, reg_wdata, dbg_addr,
        input  dbg_data, busy, halted, pc, zflag
    );

    modport slave (
        input  start, imem_we, imem_addr, imem_wdata,
        input  reg_we, reg_addr, reg_wdata, dbg_addr,
        output dbg_data, busy, halted, pc, zflag
    );

endinterface

// File: rtl/multicycle_processor_alu.sv
// Combinational ALU of the multicycle processor. Arithmetic wraps modulo
// 2**DATA_W; carry and borrow are discarded.
module processor_alu
    import multicycle_processor_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [2:0]               op,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] result,
    output logic                     zero
);

    // Operation select and zero detect
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_MOV:  result = b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~b;
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/multicycle_processor.sv
// Multicycle processor top: FSM (FETCH/DECODE/EXEC/WB), register file,
// instruction memory and PC. Each non-halting instruction takes four cycles.
// Build option MULTICYCLE_PROCESSOR_BRZ_EN turns opcode 100 from MOV into a
// PC-relative branch-if-zero with a signed {rd,rs} offset.
module multicycle_processor
    import multicycle_processor_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int IMEM_AW    = 6
) (
    input  logic                   clk1,
    input  logic                   rst,
    multicycle_processor_if.slave  bus
);

    localparam int INSTR_W = instr_width(REG_ADDR_W);
    localparam int NREGS   = 2 ** REG_ADDR_W;
    localparam int IMEM_D  = 2 ** IMEM_AW;
    localparam int OFF_W   = 2 * REG_ADDR_W;

    state_t state_q, state_d;

    logic [IMEM_AW-1:0]       pc_q;
    logic [IMEM_AW-1:0]       pc_next;
    logic                     zflag_q;
    logic [INSTR_W-1:0]       ir_p0;
    logic signed [DATA_W-1:0] a_p1;
    logic signed [DATA_W-1:0] b_p1;
    logic signed [DATA_W-1:0] res_p2;

    logic signed [DATA_W-1:0] regs [NREGS];
    logic [INSTR_W-1:0]       imem [IMEM_D];

    logic [2:0]               op_w;
    logic [REG_ADDR_W-1:0]    rd_w;
    logic [REG_ADDR_W-1:0]    rs_w;
    logic signed [DATA_W-1:0] alu_res;
    logic                     alu_zero;
    logic                     busy_w;
    logic                     wb_writes_rd;

    assign op_w = ir_p0[INSTR_W-1 -: 3];
    assign rd_w = ir_p0[OFF_W-1 -: REG_ADDR_W];
    assign rs_w = ir_p0[REG_ADDR_W-1:0];

    assign busy_w = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                    (state_q == ST_EXEC)  || (state_q == ST_WB);

    processor_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op_w),
        .a      (a_p1),
        .b      (b_p1),
        .result (alu_res),
        .zero   (alu_zero)
    );

`ifdef MULTICYCLE_PROCESSOR_BRZ_EN
    logic signed [OFF_W-1:0] br_off;
    logic [IMEM_AW-1:0]      br_off_ext;

    assign br_off     = ir_p0[OFF_W-1:0];
    assign br_off_ext = IMEM_AW'(br_off);
    assign wb_writes_rd = (op_w != OP_BRZ) && (op_w != OP_HLT);

    // Next PC: taken branch adds the sign-extended offset, otherwise step by one
    always_comb begin
        pc_next = pc_q + IMEM_AW'(1);
        if (op_w == OP_BRZ && zflag_q) begin
            pc_next = pc_q + br_off_ext;
        end
    end
`else
    assign wb_writes_rd = (op_w != OP_HLT);

    // Next PC: sequential step, wrapping at the top of instruction memory
    always_comb begin
        pc_next = pc_q + IMEM_AW'(1);
    end
`endif

    // FSM state register
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE,
            ST_HALT:   if (bus.start) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = (op_w == OP_HLT) ? ST_HALT : ST_WB;
            ST_WB:     state_d = ST_FETCH;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Control state: PC, instruction register and zero flag
    always_ff @(posedge clk1) begin
        if (rst) begin
            pc_q    <= '0;
            ir_p0   <= '0;
            zflag_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE,
                ST_HALT:  if (bus.start) pc_q <= '0;
                ST_FETCH: ir_p0 <= imem[pc_q];
                ST_EXEC:  if (updates_zflag(op_w)) zflag_q <= alu_zero;
                ST_WB:    pc_q <= pc_next;
                default:  ;
            endcase
        end
    end

    // Operand and result latches; contents are don't-care outside their stage
    always_ff @(posedge clk1) begin
        if (state_q == ST_DECODE) begin
            a_p1 <= regs[rd_w];
            b_p1 <= regs[rs_w];
        end
        if (state_q == ST_EXEC) begin
            res_p2 <= alu_res;
        end
    end

    // Register file: host preload while idle, writeback while running
    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (!busy_w && bus.reg_we) begin
            regs[bus.reg_addr] <= bus.reg_wdata;
        end else if (state_q == ST_WB && wb_writes_rd) begin
            regs[rd_w] <= res_p2;
        end
    end

    // Instruction memory: host writes while idle; contents survive reset
    always_ff @(posedge clk1) begin
        if (!rst && !busy_w && bus.imem_we) begin
            imem[bus.imem_addr] <= bus.imem_wdata;
        end
    end

    assign bus.busy     = busy_w;
    assign bus.halted   = (state_q == ST_HALT);
    assign bus.pc       = pc_q;
    assign bus.zflag    = zflag_q;
    assign bus.dbg_data = regs[bus.dbg_addr];

endmodule

// File: tb/tb_multicycle_processor.sv
// Self-checking bench for multicycle_processor (DATA_W=16, REG_ADDR_W=3,
// IMEM_AW=6). An instruction-level interpreter predicts registers, flag, PC
// and cycle count; directed programs plus random programs are compared.
// Honours MULTICYCLE_PROCESSOR_BRZ_EN for opcode 100 behaviour.
module tb_multicycle_processor;

    logic clk = 1'b0;
    logic rst;

    always #50 clk = ~clk;

    multicycle_processor_if #(.DATA_W(16), .REG_ADDR_W(3), .IMEM_AW(6)) bus ();

    multicycle_processor #(.DATA_W(16), .REG_ADDR_W(3), .IMEM_AW(6)) dut (
        .clk1 (clk),
        .rst  (rst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference machine state
    logic [8:0]  m_imem [64];
    logic [15:0] m_rf   [8];
    bit          m_z;
    int          m_pc;

`ifdef MULTICYCLE_PROCESSOR_BRZ_EN
    localparam bit BRZ = 1'b1;
`else
    localparam bit BRZ = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] enc(input int op, input int rd, input int rs);
        return 9'((op << 6) | (rd << 3) | rs);
    endfunction

    // One instruction of the reference machine
    task automatic m_step(output bit hlt);
        logic [8:0]  ins;
        logic [15:0] a, b, r;
        int          op, rd, rs, off;
        ins = m_imem[m_pc];
        op  = int'(ins[8:6]);
        rd  = int'(ins[5:3]);
        rs  = int'(ins[2:0]);
        a   = m_rf[rd];
        b   = m_rf[rs];
        hlt = 1'b0;
        r   = 16'h0;
        if (op == 5) begin
            hlt = 1'b1;
        end else if (op == 4 && BRZ) begin
            off = int'(ins[5:0]);
            if (ins[5]) off = off - 64;
            if (m_z) m_pc = (((m_pc + off) % 64) + 64) % 64;
            else     m_pc = (m_pc + 1) % 64;
        end else if (op == 4) begin
            m_rf[rd] = b;
            m_pc = (m_pc + 1) % 64;
        end else begin
            case (op)
                0: r = a + b;
                1: r = a - b;
                2: r = a & b;
                3: r = a | b;
                6: r = a ^ b;
                default: r = ~b;
            endcase
            m_rf[rd] = r;
            m_z = (r == 16'h0);
            m_pc = (m_pc + 1) % 64;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
        m_z  = 1'b0;
        m_pc = 0;
    endtask

    task automatic wr_imem(input int a, input logic [8:0] d);
        bus.imem_we    = 1'b1;
        bus.imem_addr  = 6'(a);
        bus.imem_wdata = d;
        tick();
        bus.imem_we    = 1'b0;
        m_imem[a]      = d;
    endtask

    task automatic wr_reg(input int a, input logic [15:0] d);
        bus.reg_we    = 1'b1;
        bus.reg_addr  = 3'(a);
        bus.reg_wdata = d;
        tick();
        bus.reg_we    = 1'b0;
        m_rf[a]       = d;
    endtask

    // Read a register through the combinational debug port without clocking
    task automatic rd_reg(input int a, output logic [15:0] v);
        bus.dbg_addr = 3'(a);
        #1;
        v = bus.dbg_data;
    endtask

    task automatic check_regs(input string tag);
        logic [15:0] v;
        for (int i = 0; i < 8; i++) begin
            rd_reg(i, v);
            chk($sformatf("%s.r%0d", tag, i), 32'(v), 32'(m_rf[i]));
        end
    endtask

    // Start the program at PC 0, wait for HALT, compare against the model
    task automatic run_check(input string tag);
        int steps, cyc, budget;
        bit h;
        m_pc  = 0;
        steps = 0;
        h     = 1'b0;
        while (!h && steps < 1000) begin
            m_step(h);
            steps++;
        end
        budget = 4 * steps + 20;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.halted && cyc < budget) begin
            tick();
            cyc++;
        end
        chk({tag, ".cycles"}, 32'(cyc), 32'(4 * steps));
        chk({tag, ".halted"}, 32'(bus.halted), 32'd1);
        chk({tag, ".pc"}, 32'(bus.pc), 32'(m_pc));
        chk({tag, ".z"}, 32'(bus.zflag), 32'(m_z));
        check_regs(tag);
    endtask

    function automatic int rand_op(input bit allow_4);
        int op;
        op = int'($urandom_range(0, 7));
        while (op == 5 || (op == 4 && !allow_4)) op = int'($urandom_range(0, 7));
        return op;
    endfunction

    logic [15:0] v;
    int          len, cyc;

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.imem_we    = 1'b0;
        bus.imem_addr  = '0;
        bus.imem_wdata = '0;
        bus.reg_we     = 1'b0;
        bus.reg_addr   = '0;
        bus.reg_wdata  = '0;
        bus.dbg_addr   = '0;
        for (int i = 0; i < 64; i++) m_imem[i] = 9'h0;
        tick();
        do_reset();

        // Reset state
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.halted", 32'(bus.halted), 32'd0);
        chk("rst.pc", 32'(bus.pc), 32'd0);
        chk("rst.z", 32'(bus.zflag), 32'd0);
        check_regs("rst");

        // XOR R3,R3 clears R3 and sets Z
        wr_reg(3, 16'd3);
        wr_imem(0, enc(6, 3, 3));
        wr_imem(1, enc(5, 0, 0));
        run_check("xor");
        rd_reg(3, v);
        chk("xor.r3.lit", 32'(v), 32'd0);
        chk("xor.z.lit", 32'(bus.zflag), 32'd1);
        chk("xor.pc.lit", 32'(bus.pc), 32'd1);

        // NOT R1,R0 gives all ones, Z clear
        do_reset();
        wr_imem(0, enc(7, 1, 0));
        wr_imem(1, enc(5, 0, 0));
        run_check("not");
        rd_reg(1, v);
        chk("not.r1.lit", 32'(v), 32'hFFFF);
        chk("not.z.lit", 32'(bus.zflag), 32'd0);

        // ADD wraps; then a second program SUB R2,R2 restarts from HALT
        do_reset();
        wr_reg(1, 16'hFFFF);
        wr_reg(2, 16'd2);
        wr_imem(0, enc(0, 1, 2));
        wr_imem(1, enc(5, 0, 0));
        run_check("addwrap");
        rd_reg(1, v);
        chk("addwrap.r1.lit", 32'(v), 32'h0001);
        wr_imem(0, enc(1, 2, 2));
        run_check("subself");
        rd_reg(2, v);
        chk("subself.r2.lit", 32'(v), 32'd0);
        chk("subself.z.lit", 32'(bus.zflag), 32'd1);

        // PC wraps 63 -> 0; host writes during busy are dropped
        do_reset();
        for (int i = 0; i < 8; i++) wr_reg(i, 16'($urandom));
        for (int i = 0; i < 63; i++) wr_imem(i, enc(rand_op(!BRZ), int'($urandom_range(0, 6)), int'($urandom_range(0, 7))));
        wr_imem(63, enc(0, int'($urandom_range(0, 6)), int'($urandom_range(0, 7))));
        m_pc = 0;
        for (int i = 0; i < 65; i++) begin
            bit h;
            m_step(h);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.imem_we    = 1'b1;
        bus.imem_addr  = 6'd0;
        bus.imem_wdata = enc(5, 0, 0);
        bus.reg_we     = 1'b1;
        bus.reg_addr   = 3'd7;
        bus.reg_wdata  = 16'hBEEF;
        tick();
        bus.imem_we = 1'b0;
        bus.reg_we  = 1'b0;
        for (int i = 2; i <= 4 * 65; i++) tick();
        chk("wrap.pc.lit", 32'(bus.pc), 32'd1);
        chk("wrap.pc", 32'(bus.pc), 32'(m_pc));
        chk("wrap.busy", 32'(bus.busy), 32'd1);
        chk("wrap.halted", 32'(bus.halted), 32'd0);
        chk("wrap.z", 32'(bus.zflag), 32'(m_z));
        check_regs("wrap");

        // Reset during EXEC of ADD beats a simultaneous start and preload
        do_reset();
        wr_reg(1, 16'd5);
        wr_reg(2, 16'd7);
        wr_imem(0, enc(0, 1, 2));
        wr_imem(1, enc(5, 0, 0));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst           = 1'b1;
        bus.start     = 1'b1;
        bus.reg_we    = 1'b1;
        bus.reg_addr  = 3'd3;
        bus.reg_wdata = 16'h5555;
        tick();
        rst        = 1'b0;
        bus.start  = 1'b0;
        bus.reg_we = 1'b0;
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
        m_z  = 1'b0;
        m_pc = 0;
        chk("midrst.busy", 32'(bus.busy), 32'd0);
        chk("midrst.halted", 32'(bus.halted), 32'd0);
        chk("midrst.pc", 32'(bus.pc), 32'd0);
        check_regs("midrst");
        tick();
        tick();
        chk("midrst.idle", 32'(bus.busy), 32'd0);
        wr_reg(1, 16'd5);
        wr_reg(2, 16'd7);
        run_check("rerun");
        rd_reg(1, v);
        chk("rerun.r1.lit", 32'(v), 32'd12);

`ifdef MULTICYCLE_PROCESSOR_BRZ_EN
        // Taken branch skips the ADD
        do_reset();
        wr_reg(5, 16'd9);
        wr_imem(0, enc(6, 4, 4));
        wr_imem(1, enc(4, 0, 2));
        wr_imem(2, enc(0, 5, 5));
        wr_imem(3, enc(5, 0, 0));
        run_check("brz.taken");
        rd_reg(5, v);
        chk("brz.taken.r5.lit", 32'(v), 32'd9);
        chk("brz.taken.pc.lit", 32'(bus.pc), 32'd3);
        // Not taken when Z is clear
        wr_imem(0, enc(7, 4, 0));
        run_check("brz.fall");
        rd_reg(5, v);
        chk("brz.fall.r5.lit", 32'(v), 32'd18);
`else
        // Opcode 100 moves rs to rd and leaves Z alone
        do_reset();
        wr_reg(2, 16'h1234);
        wr_imem(0, enc(6, 3, 3));
        wr_imem(1, enc(4, 0, 2));
        wr_imem(2, enc(5, 0, 0));
        run_check("mov");
        rd_reg(0, v);
        chk("mov.r0.lit", 32'(v), 32'h1234);
        chk("mov.z.lit", 32'(bus.zflag), 32'd1);
`endif

        // Random straight-line programs
        for (int t = 0; t < 10; t++) begin
            do_reset();
            for (int i = 0; i < 8; i++) wr_reg(i, 16'($urandom));
            len = int'($urandom_range(1, 20));
            for (int i = 0; i < len; i++) wr_imem(i, enc(rand_op(!BRZ), int'($urandom_range(0, 7)), int'($urandom_range(0, 7))));
            wr_imem(len, enc(5, 0, 0));
            run_check($sformatf("rnd%0d", t));
        end

        cyc = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_processor.md
MULTICYCLE_PROCESSOR -- requirements
Module: multicycle_processor

Interface
REQ-001 Parameter DATA_W, default 16, register and ALU data width (>=4).
REQ-002 Parameter REG_ADDR_W, default 3, register-index width; register file holds 2**REG_ADDR_W registers.
REQ-003 Parameter IMEM_AW, default 6, instruction-memory address width; depth 2**IMEM_AW; instruction width INSTR_W = 3 + 2*REG_ADDR_W, laid out as op[top 3] | rd | rs.
REQ-004 Clocking fixed: one clock; reset is synchronous and active-high (ports clk1 and rst).
REQ-005 clk1  in  1  sole clock, all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  single-cycle pulse; begins execution at PC 0 from IDLE or HALT.
REQ-008 imem_we / imem_addr / imem_wdata  in  1 / IMEM_AW / INSTR_W  instruction-memory write port.
REQ-009 reg_we / reg_addr / reg_wdata  in  1 / REG_ADDR_W / DATA_W  register preload port.
REQ-010 dbg_addr  in  REG_ADDR_W  register readback select; dbg_data  out  DATA_W  combinational Reg[dbg_addr].
REQ-011 busy  out  1  high in FETCH/DECODE/EXEC/WB; halted  out  1  high in HALT; pc  out  IMEM_AW  current PC; zflag  out  1  zero flag.

Function
REQ-012 FSM states IDLE, FETCH, DECODE, EXEC, WB, HALT; each non-halt instruction takes exactly 4 cycles (FETCH->DECODE->EXEC->WB->FETCH).
REQ-013 IDLE or HALT with start=1 -> FETCH next cycle with PC=0; start while busy ignored.
REQ-014 FETCH latches IR=Imem[PC]; DECODE latches A=Reg[rd], B=Reg[rs]; EXEC computes result and Z; WB writes Reg[rd] and PC=PC+1 mod 2**IMEM_AW (wraps from last address to 0).
REQ-015 Opcodes: 000 ADD rd=A+B; 001 SUB rd=A-B; 010 AND; 011 OR; 100 MOV rd=B (see REQ-024); 101 HLT; 110 XOR rd=A^B; 111 NOT rd=~B.
REQ-016 Arithmetic modulo 2**DATA_W; carry/borrow discarded; rd==rs legal, operands are pre-write values.
REQ-017 zflag updated in EXEC for ALU ops only = (result==0); HLT and MOV leave it unchanged.
REQ-018 HLT: EXEC -> HALT, no register write, PC holds HLT address; halted stays 1 until start or rst.
REQ-019 imem_we and reg_we honoured only when busy=0; dropped when busy=1.
REQ-020 reg_we and WB write never coincide (REQ-019); dbg_data reflects a write the cycle after it.

Reset
REQ-021 rst=1: state IDLE, PC=0, IR=0, zflag=0, busy=0, halted=0, all registers 0, overriding any in-flight instruction without a write.
REQ-022 Instruction memory not cleared by rst.
REQ-023 rst has priority over start, imem_we and reg_we in the same cycle.

Configuration
REQ-024 Macro MULTICYCLE_PROCESSOR_BRZ_EN: defined -> opcode 100 is BRZ: in EXEC, if zflag=1, PC = PC + sign-extended {rd,rs} (mod depth) at WB with no register write, else PC+1; undefined -> opcode 100 is MOV.

Structure
REQ-025 Package multicycle_processor_pkg holds opcode constants, FSM state type and INSTR_W derivation.
REQ-026 Combinational sub-module processor_alu (op, A, B -> result, zero); FSM, register file and memories in top.

Verification (DATA_W=16, REG_ADDR_W=3, IMEM_AW=6)
REQ-027 Preload R3=3; Imem[0]=XOR R3,R3 (9'b110011011), Imem[1]=HLT; start -> R3=0, zflag=1, halted=1 after 8 cycles, pc=1.
REQ-028 R0=0; Imem[0]=NOT R1,R0 (9'b111001000), Imem[1]=HLT -> R1=16'hFFFF, zflag=0.
REQ-029 R1=16'hFFFF, R2=2; ADD R1,R2; HLT -> R1=16'h0001; SUB R2,R2 next program -> R2=0, zflag=1.
REQ-030 63 non-HLT ops in Imem[0..62], Imem[63]=ADD, Imem[0] overwritten to HLT after start is rejected (busy) -> PC wraps 63->0, original Imem[0] re-executes.
REQ-031 rst asserted in EXEC of ADD R1,R2 -> R1=0, state IDLE, busy=0 next cycle; start then reruns program correctly.
REQ-032 BRZ_EN defined: XOR R4,R4; BRZ +2; ADD R5,R5; HLT -> ADD skipped, R5 unchanged; undefined: opcode 100 performs MOV.
